// File: rtl/axi_fft_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_fft_master_if
//  Purpose  : AXI-style write/read burst channels between the FFT burst
//             initiator (master) and the FFT slave bridge (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_fft_master_if #(
  parameter int DATA_WIDTH = 32
);
  // Write address channel
  logic [11:0]           AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;
  // Write data channel (16-bit samples)
  logic [15:0]           WDATA;
  logic [1:0]            WSTRB;
  logic                  WVALID;
  logic                  WLAST;
  logic                  WREADY;
  // Read address channel
  logic [11:0]           ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;
  // Read data channel
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RVALID;
  logic                  RLAST;
  logic                  RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID, WLAST,
    input  WREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RDATA, RVALID, RLAST,
    output RREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID, WLAST,
    output WREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RDATA, RVALID, RLAST,
    input  RREADY
  );
endinterface
`default_nettype wire

// File: rtl/axi_fft_master.sv
`default_nettype none
// ============================================================================
//  Module   : axi_fft_master
//  Purpose  : Writes an N-sample stream to the FFT bridge as one INCR burst,
//             waits for the core to finish, then reads N results back as one
//             INCR burst and forwards them to the result stream.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_fft_master #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [11:0]           i_num_samples,
  input  logic [11:0]           i_base_addr,
  input  logic [15:0]           i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic [DATA_WIDTH-1:0] o_r_data,
  output logic                  o_r_valid,
  output logic                  o_r_last,
  input  logic                  i_r_ready,
  input  logic                  i_calc_done,
  axi_fft_master_if.master      axi,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_WAIT = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_base;
  logic [7:0]  r_len;       // burst length minus one, as carried on AxLEN
  logic [8:0]  r_beat_cnt;  // shared by the write and read bursts
  logic        r_err;

  logic w_n_ok;
  logic w_at_last;
  logic w_wbeat;
  logic w_rbeat;

  assign w_n_ok    = (i_num_samples != 12'd0) && (i_num_samples <= 12'(MAX_BEATS));
  assign w_at_last = (r_beat_cnt == {1'b0, r_len});
  assign w_wbeat   = (r_state == S_W) && i_s_valid && axi.WREADY;
  assign w_rbeat   = (r_state == S_R) && axi.RVALID && i_r_ready;

  assign o_busy = (r_state != S_IDLE);
  assign o_err  = r_err;

  // State register; async reset aborts any transaction in flight
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and channel outputs; address fields come only from registers
  always_comb begin
    w_state_nxt = r_state;
    axi.AWVALID = 1'b0;
    axi.AWADDR  = 12'd0;
    axi.AWLEN   = 8'd0;
    axi.AWSIZE  = 3'd0;
    axi.AWBURST = 2'd0;
    axi.WDATA   = 16'd0;
    axi.WSTRB   = 2'd0;
    axi.WVALID  = 1'b0;
    axi.WLAST   = 1'b0;
    axi.ARVALID = 1'b0;
    axi.ARADDR  = 12'd0;
    axi.ARLEN   = 8'd0;
    axi.ARSIZE  = 3'd0;
    axi.ARBURST = 2'd0;
    axi.RREADY  = 1'b0;
    o_s_ready   = 1'b0;
    o_r_data    = '0;
    o_r_valid   = 1'b0;
    o_r_last    = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && w_n_ok) w_state_nxt = S_AW;
      end
      S_AW: begin
        axi.AWVALID = 1'b1;
        axi.AWADDR  = r_base;
        axi.AWLEN   = r_len;
        axi.AWSIZE  = 3'b001;
        axi.AWBURST = 2'b01;
        if (axi.AWREADY) w_state_nxt = S_W;
      end
      S_W: begin
        axi.WDATA  = i_s_data;
        axi.WVALID = i_s_valid;
        axi.WSTRB  = 2'b11;
        axi.WLAST  = w_at_last;
        o_s_ready  = axi.WREADY;
        if (w_wbeat && w_at_last) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_calc_done) w_state_nxt = S_AR;
      end
      S_AR: begin
        axi.ARVALID = 1'b1;
        axi.ARADDR  = r_base;
        axi.ARLEN   = r_len;
        axi.ARSIZE  = 3'b010;
        axi.ARBURST = 2'b01;
        if (axi.ARREADY) w_state_nxt = S_R;
      end
      S_R: begin
        o_r_data   = axi.RDATA;
        o_r_valid  = axi.RVALID;
        o_r_last   = w_at_last && axi.RVALID;
        axi.RREADY = i_r_ready;
        // The local count, not RLAST, decides where the burst ends
        if (w_rbeat && w_at_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, shared beat counter and one-cycle error pulse
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_base     <= 12'd0;
      r_len      <= 8'd0;
      r_beat_cnt <= 9'd0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if ((r_state == S_IDLE) && i_start) begin
        if (w_n_ok) begin
          r_base <= i_base_addr;
          r_len  <= i_num_samples[7:0] - 8'd1;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (w_wbeat || w_rbeat) begin
        r_beat_cnt <= w_at_last ? 9'd0 : r_beat_cnt + 9'd1;
      end
      if (w_rbeat && (axi.RLAST != w_at_last)) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_fft_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_fft_master
//  Purpose  : Self-checking bench for axi_fft_master: random sample/result
//             data and handshakes checked against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_fft_master;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_start;
  logic [11:0]   i_num_samples;
  logic [11:0]   i_base_addr;
  logic [15:0]   i_s_data;
  logic          i_s_valid;
  logic          o_s_ready;
  logic [DW-1:0] o_r_data;
  logic          o_r_valid;
  logic          o_r_last;
  logic          i_r_ready;
  logic          i_calc_done;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int total = 0;
  int bad   = 0;

  logic [15:0]   samples [0:256];
  logic [DW-1:0] rdata   [0:256];

  axi_fft_master_if #(.DATA_WIDTH(DW)) bus();

  axi_fft_master #(.DATA_WIDTH(DW), .MAX_BEATS(256)) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_start       (i_start),
    .i_num_samples (i_num_samples),
    .i_base_addr   (i_base_addr),
    .i_s_data      (i_s_data),
    .i_s_valid     (i_s_valid),
    .o_s_ready     (o_s_ready),
    .o_r_data      (o_r_data),
    .o_r_valid     (o_r_valid),
    .o_r_last      (o_r_last),
    .i_r_ready     (i_r_ready),
    .i_calc_done   (i_calc_done),
    .axi           (bus),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_start       = 1'b0;
    i_num_samples = 12'd0;
    i_base_addr   = 12'd0;
    i_s_data      = 16'd0;
    i_s_valid     = 1'b0;
    i_r_ready     = 1'b0;
    i_calc_done   = 1'b0;
    bus.AWREADY   = 1'b0;
    bus.WREADY    = 1'b0;
    bus.ARREADY   = 1'b0;
    bus.RDATA     = '0;
    bus.RVALID    = 1'b0;
    bus.RLAST     = 1'b0;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_awvalid"}, 32'(bus.AWVALID), 0);
    chk({tag, "_wvalid"},  32'(bus.WVALID), 0);
    chk({tag, "_sready"},  32'(o_s_ready), 0);
    chk({tag, "_arvalid"}, 32'(bus.ARVALID), 0);
    chk({tag, "_rready"},  32'(bus.RREADY), 0);
    chk({tag, "_rvalid"},  32'(o_r_valid), 0);
    chk({tag, "_busy"},    32'(o_busy), 0);
    chk({tag, "_done"},    32'(o_done), 0);
  endtask

  // Illegal N: expect one error pulse and no transaction
  task automatic bad_start(input logic [11:0] n);
    @(negedge i_clk);
    i_start = 1'b1; i_num_samples = n; i_base_addr = 12'($urandom);
    @(negedge i_clk);
    i_start = 1'b0;
    #1;
    chk("bad_err_pulse", 32'(o_err), 1);
    chk("bad_busy", 32'(o_busy), 0);
    chk("bad_awvalid", 32'(bus.AWVALID), 0);
    @(negedge i_clk);
    #1;
    chk("bad_err_clear", 32'(o_err), 0);
    chk("bad_busy2", 32'(o_busy), 0);
    chk("bad_awvalid2", 32'(bus.AWVALID), 0);
  endtask

  // One full transaction: acts as sample source, FFT bridge slave and result sink
  task automatic run_txn(input int n, input logic [11:0] base, input int mode,
                         input int aw_dly, input int ar_dly, input int calc_dly,
                         input int bad_idx, input int abort_after);
    int src = 0, wb = 0, rk = 0;
    int aw_hs = 0, ar_hs = 0, aw_seen = 0, ar_seen = 0, calc_cnt = 0;
    int done_seen = 0, err_seen = 0, exp_err = 0;
    bit w_fin = 0, calc_seen = 0, aw_wait = 0, ar_wait = 0;
    bit sacc, wbeat, rbus, rsink;
    for (int i = 0; i < n; i++) begin
      samples[i] = 16'($urandom);
      rdata[i]   = $urandom;
    end
    @(negedge i_clk);
    idle_inputs();
    i_start = 1'b1; i_num_samples = 12'(n); i_base_addr = base;
    for (int cyc = 0; cyc < 6000 && done_seen == 0; cyc++) begin
      @(negedge i_clk);
      i_start       = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_num_samples = 12'($urandom);
      i_base_addr   = 12'($urandom);
      i_s_valid     = (src < n) && (mode == 0 || $urandom_range(0, 1) == 1);
      i_s_data      = samples[src];
      bus.WREADY    = (mode == 0) || ($urandom_range(0, 1) == 1);
      bus.AWREADY   = (aw_seen >= aw_dly);
      bus.ARREADY   = (ar_seen >= ar_dly);
      i_calc_done   = w_fin && (calc_cnt >= calc_dly) && (ar_hs == 0);
      bus.RVALID    = (ar_hs > 0) && (rk < n) && (mode == 0 || $urandom_range(0, 3) != 0);
      bus.RDATA     = rdata[rk];
      bus.RLAST     = (rk == n - 1) || (rk == bad_idx);
      i_r_ready     = (mode == 0) || (cyc % 3 != 2);
      if (abort_after >= 0 && wb == abort_after && aw_hs > 0) begin
        i_s_valid = 1'b1; bus.WREADY = 1'b1;
        #1;
        chk("abort_in_w", 32'(bus.WVALID), 1);
        i_rstn = 1'b0;
        #1;
        chk_all_quiet("abort");
        chk("abort_wlast", 32'(bus.WLAST), 0);
        i_start = 1'b0;
        return;
      end
      #1;
      chk("busy_run", 32'(o_busy), 1);
      // write address channel
      if (aw_wait) chk("aw_hold", 32'(bus.AWVALID), 1);
      aw_wait = 0;
      if (bus.AWVALID) begin
        chk("aw_addr", 32'(bus.AWADDR), 32'(base));
        chk("aw_len", 32'(bus.AWLEN), 32'(n - 1));
        chk("aw_size", 32'(bus.AWSIZE), 1);
        chk("aw_burst", 32'(bus.AWBURST), 1);
        aw_seen++;
        if (bus.AWREADY) aw_hs++; else aw_wait = 1;
      end
      // write data: source acceptance must coincide with a bus beat
      sacc  = i_s_valid && o_s_ready;
      wbeat = bus.WVALID && bus.WREADY;
      chk("w_pair", 32'(sacc), 32'(wbeat));
      if (wbeat) begin
        chk("w_after_aw", 32'(aw_hs), 1);
        chk("w_extra", 32'(wb < n), 1);
        chk("w_data", 32'(bus.WDATA), 32'(samples[wb]));
        chk("w_last", 32'(bus.WLAST), 32'(wb == n - 1));
        chk("w_strb", 32'(bus.WSTRB), 3);
        wb++;
        if (wb == n) w_fin = 1;
      end
      if (sacc) src++;
      // read address channel
      if (ar_wait) chk("ar_hold", 32'(bus.ARVALID), 1);
      ar_wait = 0;
      if (bus.ARVALID) begin
        chk("ar_after_calc", 32'(calc_seen), 1);
        chk("ar_addr", 32'(bus.ARADDR), 32'(base));
        chk("ar_len", 32'(bus.ARLEN), 32'(n - 1));
        chk("ar_size", 32'(bus.ARSIZE), 2);
        chk("ar_burst", 32'(bus.ARBURST), 1);
        ar_seen++;
        if (bus.ARREADY) ar_hs++; else ar_wait = 1;
      end
      // read data: sink beat must coincide with the bus beat
      rbus  = bus.RVALID && bus.RREADY;
      rsink = o_r_valid && i_r_ready;
      chk("r_pair", 32'(rsink), 32'(rbus));
      chk("r_last_lvl", 32'(o_r_last), 32'(o_r_valid && (rk == n - 1)));
      if (rsink) chk("r_data", o_r_data, rdata[rk]);
      if (rbus) begin
        if (bus.RLAST != (rk == n - 1)) exp_err++;
        rk++;
      end
      if (o_err) err_seen++;
      if (o_done) begin
        done_seen++;
        chk("done_after_r", 32'(rk), 32'(n));
      end
      if (w_fin) calc_cnt++;
      if (i_calc_done) calc_seen = 1;
    end
    chk("done_count", 32'(done_seen), 1);
    chk("aw_handshakes", 32'(aw_hs), 1);
    chk("ar_handshakes", 32'(ar_hs), 1);
    chk("w_beats", 32'(wb), 32'(n));
    chk("src_beats", 32'(src), 32'(n));
    chk("r_beats", 32'(rk), 32'(n));
    chk("err_count", 32'(err_seen), 32'(exp_err));
    @(negedge i_clk);
    idle_inputs();
    #1;
    chk("post_busy", 32'(o_busy), 0);
    chk("post_done", 32'(o_done), 0);
    chk("post_err", 32'(o_err), 0);
    chk("post_awvalid", 32'(bus.AWVALID), 0);
  endtask

  initial begin
    idle_inputs();
    i_rstn = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    chk_all_quiet("reset");
    chk("reset_err", 32'(o_err), 0);
    chk("reset_awaddr", 32'(bus.AWADDR), 0);
    chk("reset_awlen", 32'(bus.AWLEN), 0);
    chk("reset_awsize", 32'(bus.AWSIZE), 0);
    chk("reset_awburst", 32'(bus.AWBURST), 0);
    chk("reset_arsize", 32'(bus.ARSIZE), 0);
    chk("reset_wlast", 32'(bus.WLAST), 0);
    chk("reset_rlast", 32'(o_r_last), 0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // basic N=4, no stalls, calc done 5 cycles after the write
    run_txn(4, 12'h000, 0, 0, 0, 5, -1, -1);
    // N=8 with random stream/bus stalls and periodic sink back-pressure
    run_txn(8, 12'($urandom), 1, 0, 0, $urandom_range(0, 4), -1, -1);
    // delayed address handshakes
    run_txn(6, 12'h123, 0, 3, 2, 2, -1, -1);
    // illegal sample counts
    bad_start(12'd0);
    bad_start(12'd257);
    bad_start(12'hFFF);
    // early RLAST on beat 2
    run_txn(4, 12'h0A0, 0, 0, 0, 1, 1, -1);
    // reset during the second write beat, then a fresh N=2 transaction
    run_txn(4, 12'h040, 0, 0, 0, 1, -1, 1);
    @(negedge i_clk);
    idle_inputs();
    i_rstn = 1'b1;
    run_txn(2, 12'h080, 0, 0, 0, 0, -1, -1);
    // boundary lengths
    run_txn(1, 12'($urandom), 1, 1, 1, 0, -1, -1);
    run_txn(256, 12'($urandom), 1, 0, 0, 3, -1, -1);
    // random sizes and delays
    for (int t = 0; t < 3; t++) begin
      run_txn($urandom_range(1, 40), 12'($urandom), 1, $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 6), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
